frame_deserializer: RTL and testbench
=====================================

# frame_deserializer

Multi-channel serial-to-parallel converter for the FIR filter audio front end; generalised successor of the single-word deserializer. Assembles CHANNELS words of WIDTH bits from a bit-serial stream framed by a start-of-frame strobe, with selectable bit order. Presents each complete frame on a held ready/valid output to the filter core. Reports framing errors and overruns.

## Interface
- WIDTH, 24: bits per channel word, ≥2.
- CHANNELS, 2: words per frame, ≥1.
- MSB_FIRST, 1: 1 = first serial bit is word bit WIDTH-1; 0 = first bit is word bit 0.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_en  in  1  bit strobe; i_din/i_frame sampled only when high.
- i_din  in  1  serial data bit.
- i_frame  in  1  high with the first bit of a frame (channel 0, first bit).
- i_dout_ready  in  1  consumer accepts frame.
- ov_dout  out  WIDTH*CHANNELS  frame; channel k at [k*WIDTH +: WIDTH].
- o_dout_valid  out  1  ov_dout holds an unconsumed frame.
- o_frame_err  out  1  one-cycle pulse: i_frame arrived mid-frame.
- o_overrun  out  1  one-cycle pulse: completed frame dropped, output still full.

## Operation
- States: IDLE (waiting for frame start), SHIFT (collecting bits). Counters: bit_cnt 0..WIDTH-1, ch_cnt 0..CHANNELS-1.
- IDLE: i_en & i_frame → store bit as bit 0 of channel 0, bit_cnt=1 (or wrap per WIDTH=… rule below), → SHIFT. i_en & !i_frame → bit ignored.
- SHIFT, i_en & !i_frame: store bit at position bit_cnt of word ch_cnt (MSB_FIRST maps position p to word bit WIDTH-1-p). bit_cnt wraps WIDTH-1→0 with ch_cnt+1.
- Frame complete: bit stored with bit_cnt==WIDTH-1 and ch_cnt==CHANNELS-1 → counters to 0, state → IDLE, frame offered to output stage.
- SHIFT, i_en & i_frame: o_frame_err pulses; partial frame discarded; this bit taken as bit 0 of channel 0 of a new frame; remain SHIFT.
- Output stage: on frame complete, if !o_dout_valid or i_dout_ready in that same cycle → ov_dout loaded, o_dout_valid=1. Else frame dropped, ov_dout unchanged, o_overrun pulses.
- o_dout_valid & i_dout_ready with no completing frame → o_dout_valid=0; ov_dout holds last value.
- i_en low: state, counters, shift storage frozen; output handshake still operates.
- Back-to-back frames: i_frame on the i_en cycle directly after completion is a legal start, no error.
- Unwritten bits of the assembly buffer are don't-care internally; ov_dout only updates with complete frames.

## Timing
- Reset: ov_dout=0, o_dout_valid=0, o_frame_err=0, o_overrun=0, state IDLE, counters 0, assembly buffer 0. i_rst overrides all inputs, including mid-frame (partial frame lost, no error pulse).
- Latency: last bit sampled at edge N → ov_dout/o_dout_valid valid after edge N (1 cycle registered).
- Handshake transfer at any edge with o_dout_valid & i_dout_ready; new frame may load in the same edge (no bubble, no overrun).
- o_frame_err, o_overrun: registered, high exactly one cycle after the causing edge.
- One i_en bit per cycle max; i_en may be high every cycle.

## Test plan
- WIDTH=8, CHANNELS=2, MSB_FIRST=1: serial bits of 0xA5 then 0x3C, i_frame on first bit, ready=1 → ov_dout=0x3CA5, o_dout_valid one cycle after 16th i_en edge, then low.
- Same with MSB_FIRST=0, words sent LSB first → ov_dout=0x3CA5; i_en gapped randomly → identical result, valid timing tracks last i_en.
- ready=0, two frames 0x1122 then 0x3344 → ov_dout stays 0x1122, o_overrun pulses once at second completion; ready=1 → valid drops.
- i_frame reasserted at bit 5 of channel 1, then clean frame 0xBEEF → o_frame_err single pulse, ov_dout=0xBEEF, no partial output.
- ready=1 held, frame completes on edge where valid already high → ov_dout replaced, valid stays high, no overrun.
- i_rst at bit 10 of a frame, then full frame 0x0F0F → all outputs 0 after reset, next output 0x0F0F, no error.

Source files
------------

// File: rtl/frame_deserializer.sv
// Serial-to-parallel frame assembler: collects CHANNELS words of WIDTH bits after a
// start-of-frame strobe and presents the finished frame on a held valid/ready output.
module frame_deserializer #(
  parameter int WIDTH     = 24,
  parameter int CHANNELS  = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_din,
  input  logic                      i_frame,
  input  logic                      i_dout_ready,
  output logic [WIDTH*CHANNELS-1:0] ov_dout,
  output logic                      o_dout_valid,
  output logic                      o_frame_err,
  output logic                      o_overrun,
  output logic                      o_dbg_state
);

  // Output handshake: a frame transfers on any edge where o_dout_valid and i_dout_ready
  // are both high; o_dout_valid never drops without such a transfer.

  localparam int FW = WIDTH * CHANNELS;
  localparam int BW = $clog2(WIDTH);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int IW = $clog2(FW);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   ch_cnt_q, ch_cnt_d;
  logic [FW-1:0]   buf_q, buf_d;
  logic [FW-1:0]   dout_q, dout_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            ovr_q, ovr_d;

  logic            start;
  logic            store;
  logic            complete;
  logic [BW-1:0]   wr_bit;
  logic [CW-1:0]   wr_ch;
  logic [BW-1:0]   wr_pos;
  logic [IW-1:0]   wr_idx;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    buf_d     = buf_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    ovr_d     = 1'b0;
    complete  = 1'b0;

    // A strobed i_frame always restarts at channel 0, bit 0, whatever the state.
    start  = i_en & i_frame;
    store  = start | (i_en & (state_q == ST_SHIFT));
    wr_bit = start ? '0 : bit_cnt_q;
    wr_ch  = start ? '0 : ch_cnt_q;
    wr_pos = (MSB_FIRST != 0) ? (BW'(WIDTH - 1) - wr_bit) : wr_bit;
    wr_idx = IW'(int'(wr_ch) * WIDTH + int'(wr_pos));

    if (store) begin
      buf_d[wr_idx] = i_din;
    end

    if (start) begin
      err_d     = (state_q == ST_SHIFT);
      state_d   = ST_SHIFT;
      bit_cnt_d = BW'(1);
      ch_cnt_d  = '0;
    end else if (store) begin
      if (bit_cnt_q == BW'(WIDTH - 1)) begin
        bit_cnt_d = '0;
        if (ch_cnt_q == CW'(CHANNELS - 1)) begin
          ch_cnt_d = '0;
          state_d  = ST_IDLE;
          complete = 1'b1;
        end else begin
          ch_cnt_d = ch_cnt_q + CW'(1);
        end
      end else begin
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end

    // A consumer taking the old frame this edge frees the slot for the new one.
    if (complete) begin
      if (!valid_q || i_dout_ready) begin
        dout_d  = buf_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && i_dout_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      ch_cnt_q  <= '0;
      buf_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ch_cnt_q  <= ch_cnt_d;
      buf_q     <= buf_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign ov_dout      = dout_q;
  assign o_dout_valid = valid_q;
  assign o_frame_err  = err_q;
  assign o_overrun    = ovr_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_frame_deserializer.sv
// Bench for frame_deserializer: an MSB-first and an LSB-first instance share framing and
// handshake inputs and are checked every cycle against a bit-list model plus literal values.
module tb_frame_deserializer;

  localparam int W  = 8;
  localparam int C  = 2;
  localparam int FW = W * C;

  logic          clk = 1'b0;
  logic          rst, en, frm, din_m, din_l, rdy;
  logic [FW-1:0] dout_m, dout_l;
  logic          vld_m, vld_l, err_m, err_l, ovr_m, ovr_l, st_m, st_l;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;
  int cnt_err = 0;
  int cnt_ovr = 0;

  logic [FW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  frame_deserializer #(.WIDTH(W), .CHANNELS(C), .MSB_FIRST(1)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_din(din_m), .i_frame(frm),
    .i_dout_ready(rdy), .ov_dout(dout_m), .o_dout_valid(vld_m),
    .o_frame_err(err_m), .o_overrun(ovr_m), .o_dbg_state(st_m)
  );

  frame_deserializer #(.WIDTH(W), .CHANNELS(C), .MSB_FIRST(0)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_din(din_l), .i_frame(frm),
    .i_dout_ready(rdy), .ov_dout(dout_l), .o_dout_valid(vld_l),
    .o_frame_err(err_l), .o_overrun(ovr_l), .o_dbg_state(st_l)
  );

  // ---------------- model: list of received bits per instance ----------------
  bit            mbits[2][FW];
  int            mcnt[2]   = '{0, 0};
  logic [FW-1:0] m_dout[2] = '{'0, '0};
  logic          m_vld[2]  = '{1'b0, 1'b0};
  logic          m_err[2]  = '{1'b0, 1'b0};
  logic          m_ovr[2]  = '{1'b0, 1'b0};
  bit            m_load[2] = '{1'b0, 1'b0};

  function automatic logic [FW-1:0] assemble(int i);
    logic [FW-1:0] r;
    logic [W-1:0]  w;
    r = '0;
    for (int k = 0; k < C; k++) begin
      w = '0;
      for (int p = 0; p < W; p++) begin
        if (i == 0) w = {w[W-2:0], mbits[i][k*W+p]};
        else        w[p] = mbits[i][k*W+p];
      end
      r[k*W +: W] = w;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic d;
      bit   done;
      d    = (i == 0) ? din_m : din_l;
      done = 1'b0;
      m_err[i]  = 1'b0;
      m_ovr[i]  = 1'b0;
      m_load[i] = 1'b0;
      if (rst) begin
        mcnt[i]  = 0;
        m_dout[i] = '0;
        m_vld[i]  = 1'b0;
      end else begin
        if (en) begin
          if (frm) begin
            m_err[i]     = (mcnt[i] != 0);
            mbits[i][0]  = d;
            mcnt[i]      = 1;
          end else if (mcnt[i] != 0) begin
            mbits[i][mcnt[i]] = d;
            mcnt[i]++;
            if (mcnt[i] == FW) begin
              done    = 1'b1;
              mcnt[i] = 0;
            end
          end
        end
        if (done) begin
          if (!m_vld[i] || rdy) begin
            m_dout[i] = assemble(i);
            m_vld[i]  = 1'b1;
            m_load[i] = 1'b1;
          end else begin
            m_ovr[i] = 1'b1;
          end
        end else if (m_vld[i] && rdy) begin
          m_vld[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("dout_msb",  32'(dout_m), 32'(m_dout[0]));
      check("dout_lsb",  32'(dout_l), 32'(m_dout[1]));
      check("valid_msb", 32'(vld_m),  32'(m_vld[0]));
      check("valid_lsb", 32'(vld_l),  32'(m_vld[1]));
      check("ferr_msb",  32'(err_m),  32'(m_err[0]));
      check("ferr_lsb",  32'(err_l),  32'(m_err[1]));
      check("ovr_msb",   32'(ovr_m),  32'(m_ovr[0]));
      check("ovr_lsb",   32'(ovr_l),  32'(m_ovr[1]));
      if (m_load[0]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_load", 32'(m_load[0]), 32'd0);
        end else begin
          logic [FW-1:0] e;
          e = exp_q.pop_front();
          check("load_msb", 32'(dout_m), 32'(e));
          check("load_lsb", 32'(dout_l), 32'(e));
        end
      end
      cnt_err += int'(err_m);
      cnt_ovr += int'(ovr_m);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(int n);
    repeat (n) begin
      en  = 1'b0;
      frm = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_bit(logic bm, logic bl, logic f);
    en    = 1'b1;
    din_m = bm;
    din_l = bl;
    frm   = f;
    @(negedge clk);
    en  = 1'b0;
    frm = 1'b0;
  endtask

  // f is {ch1, ch0}; rdy_last >= 0 sets i_dout_ready for the final bit only.
  task automatic send_frame(logic [FW-1:0] f, int nbits, int gapmax, int rdy_last);
    for (int n = 0; n < nbits; n++) begin
      int k;
      int p;
      k = n / W;
      p = n % W;
      if (gapmax > 0) idle($urandom_range(0, gapmax));
      if (n == FW - 1 && rdy_last >= 0) rdy = rdy_last[0];
      send_bit(f[k*W + W-1-p], f[k*W + p], n == 0);
    end
  endtask

  task automatic lit(string nm, logic [FW-1:0] dm, logic [FW-1:0] dl, logic vm, logic vl);
    check({nm, "_dout_m"}, 32'(dout_m), 32'(dm));
    check({nm, "_dout_l"}, 32'(dout_l), 32'(dl));
    check({nm, "_vld_m"},  32'(vld_m),  32'(vm));
    check({nm, "_vld_l"},  32'(vld_l),  32'(vl));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e0;
    int o0;
    rst = 1'b1; en = 1'b0; frm = 1'b0; din_m = 1'b0; din_l = 1'b0; rdy = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lit("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("reset_ferr", 32'(err_m | err_l), 32'd0);
    check("reset_ovr",  32'(ovr_m | ovr_l), 32'd0);
    idle(2);

    // Basic frame, ready held high: valid for exactly one cycle.
    exp_q.push_back(16'h3CA5);
    send_frame(16'h3CA5, FW, 0, -1);
    lit("basic", 16'h3CA5, 16'h3CA5, 1'b1, 1'b1);
    idle(1);
    lit("basic_drop", 16'h3CA5, 16'h3CA5, 1'b0, 1'b0);

    // Same frame with random gaps in i_en.
    exp_q.push_back(16'h3CA5);
    send_frame(16'h3CA5, FW, 3, -1);
    lit("gapped", 16'h3CA5, 16'h3CA5, 1'b1, 1'b1);
    idle(2);

    // Overrun: ready low, two back-to-back frames.
    rdy = 1'b0;
    o0  = cnt_ovr;
    e0  = cnt_err;
    exp_q.push_back(16'h1122);
    send_frame(16'h1122, FW, 0, -1);
    send_frame(16'h3344, FW, 0, -1);
    check("ovr_pulse_now", 32'(ovr_m & ovr_l), 32'd1);
    lit("ovr_hold", 16'h1122, 16'h1122, 1'b1, 1'b1);
    idle(1);
    check("ovr_once", 32'(cnt_ovr - o0), 32'd1);
    check("b2b_no_err", 32'(cnt_err - e0), 32'd0);
    rdy = 1'b1;
    idle(1);
    lit("ovr_release", 16'h1122, 16'h1122, 1'b0, 1'b0);

    // Framing error at bit 5 of channel 1, then a clean frame.
    e0 = cnt_err;
    send_frame(16'h5A5A, 13, 0, -1);
    lit("partial", 16'h1122, 16'h1122, 1'b0, 1'b0);
    exp_q.push_back(16'hBEEF);
    send_frame(16'hBEEF, FW, 0, -1);
    lit("after_err", 16'hBEEF, 16'hBEEF, 1'b1, 1'b1);
    check("ferr_once", 32'(cnt_err - e0), 32'd1);
    idle(2);

    // Completion on an edge where valid is high and ready is high: replace, no overrun.
    rdy = 1'b0;
    o0  = cnt_ovr;
    exp_q.push_back(16'h1234);
    send_frame(16'h1234, FW, 0, -1);
    lit("hold_a", 16'h1234, 16'h1234, 1'b1, 1'b1);
    exp_q.push_back(16'h5678);
    send_frame(16'h5678, FW, 0, 1);
    lit("replace", 16'h5678, 16'h5678, 1'b1, 1'b1);
    check("replace_no_ovr", 32'(cnt_ovr - o0), 32'd0);
    idle(1);
    lit("replace_drop", 16'h5678, 16'h5678, 1'b0, 1'b0);

    // Reset mid-frame with i_en/i_frame asserted, then a clean frame.
    e0 = cnt_err;
    send_frame(16'hFFFF, 10, 0, -1);
    rst = 1'b1; en = 1'b1; frm = 1'b1; din_m = 1'b1; din_l = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b0; frm = 1'b0;
    lit("mid_reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
    exp_q.push_back(16'h0F0F);
    send_frame(16'h0F0F, FW, 0, -1);
    lit("post_reset", 16'h0F0F, 16'h0F0F, 1'b1, 1'b1);
    check("reset_no_err", 32'(cnt_err - e0), 32'd0);
    idle(3);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
